mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 STARVE_MAX, default 4, max consecutive load/store grants while fetch waits; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 if_req  input  1  fetch read request; held with if_addr stable until granted.
REQ-005 if_addr  input  `ADDR_W  fetch word address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  fetch read data valid this cycle.
REQ-008 if_rdata  output  `DATA_W  fetch read data.
REQ-009 ls_req  input  1  load/store request from execute stage; held stable with addr/we/wdata until granted.
REQ-010 ls_addr  input  `ADDR_W  load/store word address.
REQ-011 ls_we  input  `DATA_W/8  byte write enables; all-zero means load.
REQ-012 ls_wdata  input  `DATA_W  store data.
REQ-013 ls_gnt  output  1  load/store request accepted this cycle.
REQ-014 ls_rvalid  output  1  load data valid this cycle.
REQ-015 ls_rdata  output  `DATA_W  load data.
REQ-016 mem_en  output  1  memory port enable.
REQ-017 mem_addr  output  `ADDR_W  memory port address.
REQ-018 mem_we  output  `DATA_W/8  memory byte write enables.
REQ-019 mem_wdata  output  `DATA_W  memory write data.
REQ-020 mem_rdata  input  `DATA_W  memory read data, valid exactly 1 cycle after mem_en with mem_we==0.

Function
REQ-021 Grant is combinational: at most one of if_gnt/ls_gnt high per cycle; gnt only when the matching req is high.
REQ-022 Priority: ls over if, except when starve_cnt==STARVE_MAX and if_req=1, then if is granted.
REQ-023 starve_cnt (4 bits): +1 when ls_gnt=1 and if_req=1; cleared when if_gnt=1 or if_req=0; saturates at STARVE_MAX.
REQ-024 Memory mux: granted requester drives mem_addr/mem_we/mem_wdata, mem_en=1; fetch grant forces mem_we=0, mem_wdata=0.
REQ-025 No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-026 Read tracking: on a read grant (if grant, or ls grant with ls_we==0), a 2-bit owner register {pend_valid, pend_is_ls} is loaded; otherwise pend_valid=0 next cycle.
REQ-027 Response: cycle after read grant, pend_valid=1 raises exactly one of if_rvalid/ls_rvalid per pend_is_ls, for one cycle.
REQ-028 if_rdata and ls_rdata = mem_rdata unconditionally; data meaningful only with matching rvalid.
REQ-029 Stores (ls_we!=0) produce no rvalid; a store grant at cycle N does not disturb a read response in cycle N from a grant at N-1.
REQ-030 Back-to-back: a new grant is allowed every cycle; responses pipeline with 1-cycle latency, no bubbles.
REQ-031 Fixed latency: grant cycle N -> rvalid cycle N+1, no exceptions.

Reset
REQ-032 When rst=1 at posedge: starve_cnt=0, pend_valid=0, pend_is_ls=0.
REQ-033 During rst=1 cycles: if_gnt=0, ls_gnt=0, mem_en=0, mem_we=0, if_rvalid=0, ls_rvalid=0.
REQ-034 Reset mid-operation: read granted in cycle before rst asserted produces no rvalid after reset.

Verification
REQ-035 if_req=1 only, if_addr=0x40, mem_rdata=0xAA..AA -> if_gnt=1 cycle N, mem_en=1, mem_addr=0x40; if_rvalid=1 cycle N+1, if_rdata=0xAA..AA.
REQ-036 ls_req=1, ls_we=0x0F, ls_addr=0x10, ls_wdata=0x1234 -> ls_gnt=1, mem_we=0x0F, mem_wdata=0x1234; no rvalid next cycle.
REQ-037 if_req and ls_req (loads) held high continuously, STARVE_MAX=4 -> grant pattern ls,ls,ls,ls,if repeating; rvalid owner sequence matches grants one cycle later.
REQ-038 Alternating load (ls) and fetch grants every cycle -> rvalid alternates ls/if each cycle with no gaps, correct rdata routing.
REQ-039 Read granted cycle N, rst=1 cycle N+1 -> if_rvalid=ls_rvalid=0 at N+1 and N+2; starve_cnt=0.
REQ-040 starve_cnt=3, if_req drops for one cycle while ls granted -> counter clears to 0; next forced if grant only after 4 further ls grants.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of signals between the fetch and load/store requesters, the shared
// single-port memory, and the arbiter that multiplexes them.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic [BE_W-1:0]   ls_we;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Requesters plus memory model side.
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_addr, ls_we, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_addr, ls_we, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, load/store
// first with a bounded starvation counter for fetch; reads respond one cycle later.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned STARVE_W = 4;

  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_cnt_nxt;
  logic                pend_valid;
  logic                pend_is_ls;

  logic starved_c;
  logic if_gnt_c;
  logic ls_gnt_c;
  logic ls_read_c;

  // Grant selection; everything is squashed while reset is held.
  always_comb begin
    starved_c = (starve_cnt == STARVE_W'(STARVE_MAX));
    if_gnt_c  = 1'b0;
    ls_gnt_c  = 1'b0;
    if (!rst) begin
      if (bus.if_req && (starved_c || !bus.ls_req)) begin
        if_gnt_c = 1'b1;
      end else if (bus.ls_req) begin
        ls_gnt_c = 1'b1;
      end
    end
    ls_read_c = ls_gnt_c && (bus.ls_we == '0);
  end

  // Starvation counter: counts load/store wins while fetch keeps waiting.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!bus.if_req || if_gnt_c) begin
      starve_cnt_nxt = '0;
    end else if (ls_gnt_c && !starved_c) begin
      starve_cnt_nxt = starve_cnt + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      pend_valid <= 1'b0;
      pend_is_ls <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      pend_valid <= if_gnt_c || ls_read_c;
      pend_is_ls <= ls_read_c;
    end
  end

  // Memory port mux; fetch is read-only so its write fields are forced to zero.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = '0;
    bus.mem_wdata = '0;
    if (if_gnt_c) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.if_addr;
    end else if (ls_gnt_c) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = bus.ls_addr;
      bus.mem_we    = bus.ls_we;
      bus.mem_wdata = bus.ls_wdata;
    end
  end

  assign bus.if_gnt = if_gnt_c;
  assign bus.ls_gnt = ls_gnt_c;

  // A response pending across a reset assertion is dropped.
  assign bus.if_rvalid = !rst && pend_valid && !pend_is_ls;
  assign bus.ls_rvalid = !rst && pend_valid && pend_is_ls;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ls_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic
// against a behavioural arbitration and memory model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned SM = 4;

  typedef struct {
    int            cyc;
    bit            is_ls;
    logic [DW-1:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit armed = 0;
  resp_t q[$];

  bit            e_if_gnt, e_ls_gnt, e_en;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_we;
  logic [DW-1:0] e_wdata;

  int  waited = 0;
  bit  last_if_gnt, last_ls_gnt;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] emu_mem [int];

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 32'h40) return {DW{1'b1}} / 3 * 2;  // 0xAAAA_AAAA
    return DW'(a * 32'h9E37_79B1) ^ DW'(32'h5A5A_0F0F);
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [BW-1:0] we,
                                          input logic [DW-1:0] wd);
    logic [DW-1:0] w = old;
    for (int b = 0; b < int'(BW); b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
    return w;
  endfunction

  // Memory emulation: reacts to the DUT's port, one-cycle read latency.
  always @(posedge clk) begin
    int a;
    logic [DW-1:0] cur;
    a = int'(bus.mem_addr[7:0]);
    cur = emu_mem.exists(a) ? emu_mem[a] : init_val(a);
    if (bus.mem_en && bus.mem_we == '0) bus.mem_rdata <= cur;
    else bus.mem_rdata <= DW'($urandom());
    if (bus.mem_en && bus.mem_we != '0) emu_mem[a] = merge(cur, bus.mem_we, bus.mem_wdata);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: compares grant/mux outputs and pops expected read responses.
  always @(negedge clk) begin
    resp_t r;
    bit ev_if, ev_ls;
    logic [DW-1:0] ed;
    if (armed) begin
      chk("if_gnt", 64'(bus.if_gnt), 64'(e_if_gnt));
      chk("ls_gnt", 64'(bus.ls_gnt), 64'(e_ls_gnt));
      chk("mem_en", 64'(bus.mem_en), 64'(e_en));
      chk("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
      chk("mem_we", 64'(bus.mem_we), 64'(e_we));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(e_wdata));
      ev_if = 0; ev_ls = 0; ed = '0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        r = q.pop_front();
        if (!rst) begin
          ev_if = !r.is_ls;
          ev_ls = r.is_ls;
          ed = r.data;
        end
      end
      chk("if_rvalid", 64'(bus.if_rvalid), 64'(ev_if));
      chk("ls_rvalid", 64'(bus.ls_rvalid), 64'(ev_ls));
      if (ev_if) chk("if_rdata", 64'(bus.if_rdata), 64'(ed));
      if (ev_ls) chk("ls_rdata", 64'(bus.ls_rdata), 64'(ed));
    end
  end

  // One cycle of stimulus plus the reference model's expectation for it.
  task automatic step(input bit r, input bit ir, input logic [AW-1:0] ia, input bit lr,
                      input logic [AW-1:0] la, input logic [BW-1:0] lw, input logic [DW-1:0] ld);
    bit gi, gl;
    int a;
    logic [DW-1:0] cur;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    bus.if_req = ir; bus.if_addr = ia;
    bus.ls_req = lr; bus.ls_addr = la; bus.ls_we = lw; bus.ls_wdata = ld;
    gi = 0; gl = 0;
    if (!r) begin
      if (ir && (waited >= int'(SM) || !lr)) gi = 1;
      else if (lr) gl = 1;
    end
    e_if_gnt = gi; e_ls_gnt = gl; e_en = gi || gl;
    e_addr = gi ? ia : (gl ? la : '0);
    e_we = gl ? lw : '0;
    e_wdata = gl ? ld : '0;
    if (r || !ir || gi) waited = 0;
    else if (gl && waited < int'(SM)) waited++;
    a = int'(gi ? ia[7:0] : la[7:0]);
    cur = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    if (gi) q.push_back(resp_t'{cyc + 1, 1'b0, cur});
    if (gl && lw == '0) q.push_back(resp_t'{cyc + 1, 1'b1, cur});
    if (gl && lw != '0) ref_mem[a] = merge(cur, lw, ld);
    last_if_gnt = gi; last_ls_gnt = gl;
    armed = 1;
  endtask

  initial begin
    bit ir, lr;
    logic [AW-1:0] ia, la;
    logic [BW-1:0] lw;
    logic [DW-1:0] ld;
    rst = 1'b1;
    bus.if_req = 0; bus.if_addr = '0;
    bus.ls_req = 0; bus.ls_addr = '0; bus.ls_we = '0; bus.ls_wdata = '0;

    // Reset with both requesters asserting: nothing may be granted.
    repeat (3) step(1, 1, 32'h8, 1, 32'h9, '0, '0);
    // Lone fetch of 0x40, then a byte-masked store.
    step(0, 1, 32'h40, 0, '0, '0, '0);
    step(0, 0, '0, 0, '0, '0, '0);
    step(0, 0, '0, 1, 32'h10, 4'hF, 32'h1234);
    step(0, 0, '0, 0, '0, '0, '0);
    // Both loads held: expect ls x4 then fetch, repeating.
    repeat (15) step(0, 1, 32'h20, 1, 32'h10, '0, '0);
    step(0, 0, '0, 0, '0, '0, '0);
    // Alternating load / fetch with back-to-back responses.
    for (int i = 0; i < 6; i++) begin
      step(0, 0, '0, 1, AW'(i + 1), '0, '0);
      step(0, 1, AW'(i + 32), 0, '0, '0, '0);
    end
    // Reset right after a read grant drops its response.
    step(0, 0, '0, 1, 32'h10, '0, '0);
    step(1, 0, '0, 0, '0, '0, '0);
    step(0, 0, '0, 0, '0, '0, '0);
    step(0, 1, 32'h44, 0, '0, '0, '0);
    // Counter at 3, fetch drops once: four fresh ls wins needed before fetch.
    repeat (3) step(0, 1, 32'h21, 1, 32'h11, '0, '0);
    step(0, 0, '0, 1, 32'h11, '0, '0);
    repeat (6) step(0, 1, 32'h21, 1, 32'h11, '0, '0);

    // Random traffic; requests stay stable until granted.
    ir = 0; lr = 0; ia = '0; la = '0; lw = '0; ld = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!ir || last_if_gnt) begin
        ir = ($urandom_range(0, 99) < 60);
        ia = AW'($urandom_range(0, 255));
      end
      if (!lr || last_ls_gnt) begin
        lr = ($urandom_range(0, 99) < 70);
        la = AW'($urandom_range(0, 255));
        lw = ($urandom_range(0, 1) == 0) ? '0 : BW'($urandom_range(1, (1 << BW) - 1));
        ld = DW'($urandom());
      end
      step(($urandom_range(0, 299) == 0), ir, ia, lr, la, lw, ld);
    end
    repeat (2) step(0, 0, '0, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
